// File: rtl/fetch_queue_pkg.sv
// Shared widths, sizes and entry layout for the fetch queue.
package fetch_queue_pkg;

    // Instruction-memory address width and instruction width.
    localparam int PC_W    = 5;
    localparam int INST_W  = 16;

    // Queue capacity (power of two, at least 2) and derived widths.
    localparam int DEPTH   = 4;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = PC_W + INST_W;

    // Capacity expressed in the occupancy counter's own width.
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // One buffered fetch: the PC it came from and the word read there.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

    // Advance a ring pointer; wraps naturally because DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory, commit and decode.
//
// Dequeue handshake: the queue raises deq_valid while it holds a head entry
// (and no redirect is in progress); deq_pc/deq_inst stay stable while
// deq_valid is high. The entry transfers on a rising edge where
// deq_valid && deq_ready are both high. deq_ready may depend on anything
// except deq_valid; deq_valid never depends on deq_ready.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              deq_valid;
    logic              deq_ready;
    logic [PC_W-1:0]   deq_pc;
    logic [INST_W-1:0] deq_inst;
    logic [CNT_W-1:0]  count;
    logic [PC_W-1:0]   fetch_pc;

    // Queue side.
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output deq_valid,
        input  deq_ready,
        output deq_pc,
        output deq_inst,
        output count,
        output fetch_pc
    );

    // Environment side (memory, commit, decode).
    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  deq_valid,
        output deq_ready,
        input  deq_pc,
        input  deq_inst,
        input  count,
        input  fetch_pc
    );

endinterface

// File: rtl/fq_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// combinational read port. Contents are not reset; the owner gates reads.
module fq_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 21,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Capture the incoming entry at the tail slot.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: owns the fetch PC, reads instruction memory
// every cycle it has room, and buffers {pc, inst} pairs in order for decode.
// A commit-time redirect flushes everything and restarts from redirect_pc.
module fetch_queue
    import fetch_queue_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;

    logic      full;
    logic      deq_valid;
    logic      deq_fire;
    logic      enq;
    fq_entry_t wr_entry;
    fq_entry_t head_entry;

    // Handshake qualifiers; a redirect cycle blocks both enqueue and dequeue.
    always_comb begin
        full      = (count_q == DEPTH_CNT);
        deq_valid = (count_q != '0) && !bus.redirect_valid;
        deq_fire  = deq_valid && bus.deq_ready;
        enq       = !bus.redirect_valid && (!full || deq_fire);
    end

    // Next-state for pointers, occupancy and fetch PC; redirect wins outright.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = bus.redirect_pc;
        end else begin
            if (enq) begin
                tail_d     = ptr_inc(tail_q);
                fetch_pc_d = fetch_pc_q + PC_W'(1);
            end
            if (deq_fire) begin
                head_d = ptr_inc(head_q);
            end
            case ({enq, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears everything except the entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // The word fetched this cycle is paired with the PC that addressed it.
    always_comb begin
        wr_entry.pc   = fetch_pc_q;
        wr_entry.inst = bus.imem_data;
    end

    fq_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .wen   (enq),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (head_entry)
    );

    // Outputs: head data is gated so nothing stale leaks when empty or flushing.
    always_comb begin
        bus.imem_addr = fetch_pc_q;
        bus.fetch_pc  = fetch_pc_q;
        bus.count     = count_q;
        bus.deq_valid = deq_valid;
        bus.deq_pc    = deq_valid ? head_entry.pc   : '0;
        bus.deq_inst  = deq_valid ? head_entry.inst : '0;
    end

    // Occupancy never exceeds capacity.
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= DEPTH_CNT);

    // An empty queue presents nothing.
    a_empty_quiet: assert property (@(posedge clk) disable iff (rst)
        (count_q == '0) |-> (!bus.deq_valid && bus.deq_pc == '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a reference model tracks the fetch PC and occupancy,
// pushes each expected {pc, inst} into a queue when it is fetched, and pops
// it when the queue hands an entry to the consumer.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk;
    logic rst;

    fetch_queue_if bus ();

    fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: word at address a is 0x1000 + a.
    assign bus.imem_data = 16'h1000 + {{(INST_W-PC_W){1'b0}}, bus.imem_addr};

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fail_cnt  = 0;

    // Reference model state.
    logic [PC_W-1:0]    m_pc;
    int                 m_count;
    logic [ENTRY_W-1:0] exp_q[$];

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [PC_W-1:0] pc);
        logic [INST_W-1:0] w;
        w = 16'h1000 + {{(INST_W-PC_W){1'b0}}, pc};
        return {pc, w};
    endfunction

    // Driver: hold reset across two edges, then release at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_ready      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_pc    = '0;
        m_count = 0;
        exp_q.delete();
    endtask

    // One clock: scoreboard check of the dequeue side, model step, advance.
    // Called at a falling edge with this cycle's inputs already driven.
    task automatic cycle();
        logic               dv;
        logic               fire;
        logic               enq;
        logic [ENTRY_W-1:0] exp;
        #1;
        dv   = (m_count != 0) && !bus.redirect_valid;
        fire = dv && bus.deq_ready;
        enq  = !bus.redirect_valid && ((m_count != DEPTH) || fire);
        tests_run++;
        if (bus.deq_valid !== dv) begin
            fail_cnt++;
            $display("FAIL sb_deq_valid: got %0b expected %0b", bus.deq_valid, dv);
        end
        if (fire) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                fail_cnt++;
                $display("FAIL sb_underflow: model fired with empty expected queue");
            end else begin
                exp = exp_q.pop_front();
                tests_run++;
                if ({bus.deq_pc, bus.deq_inst} !== exp) begin
                    fail_cnt++;
                    $display("FAIL sb_entry: got pc=%h inst=%h expected pc=%h inst=%h",
                             bus.deq_pc, bus.deq_inst, exp[ENTRY_W-1:INST_W], exp[INST_W-1:0]);
                end
            end
        end else if (!dv) begin
            tests_run++;
            if (bus.deq_pc !== '0 || bus.deq_inst !== '0) begin
                fail_cnt++;
                $display("FAIL sb_idle_zero: got pc=%h inst=%h expected 0/0",
                         bus.deq_pc, bus.deq_inst);
            end
        end
        if (bus.redirect_valid) begin
            exp_q.delete();
            m_count = 0;
            m_pc    = bus.redirect_pc;
        end else begin
            if (enq) begin
                exp_q.push_back(mk_entry(m_pc));
                m_pc = m_pc + PC_W'(1);
            end
            if (enq && !fire) m_count++;
            if (!enq && fire) m_count--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_ready      = 1'b0;
        #2;
        tests_run++;
        if (bus.count !== '0 || bus.fetch_pc !== '0 || bus.imem_addr !== '0 ||
            bus.deq_valid !== 1'b0 || bus.deq_pc !== '0 || bus.deq_inst !== '0) begin
            fail_cnt++;
            $display("FAIL reset_state: got count=%0d pc=%h addr=%h dv=%0b dpc=%h dinst=%h expected all 0",
                     bus.count, bus.fetch_pc, bus.imem_addr, bus.deq_valid, bus.deq_pc, bus.deq_inst);
        end
        do_reset();
    endtask

    task automatic test_fill();
        bus.deq_ready = 1'b0;
        repeat (4) cycle();
        tests_run++;
        if (bus.count !== CNT_W'(4) || bus.fetch_pc !== PC_W'(4)) begin
            fail_cnt++;
            $display("FAIL fill_count: got count=%0d pc=%h expected 4/04", bus.count, bus.fetch_pc);
        end
        tests_run++;
        if (bus.deq_valid !== 1'b1 || bus.deq_pc !== PC_W'(0) || bus.deq_inst !== 16'h1000) begin
            fail_cnt++;
            $display("FAIL fill_head: got dv=%0b pc=%h inst=%h expected 1/00/1000",
                     bus.deq_valid, bus.deq_pc, bus.deq_inst);
        end
        repeat (2) cycle();
        tests_run++;
        if (bus.count !== CNT_W'(4) || bus.imem_addr !== PC_W'(4)) begin
            fail_cnt++;
            $display("FAIL fill_hold: got count=%0d addr=%h expected 4/04", bus.count, bus.imem_addr);
        end
    endtask

    task automatic test_full_drain();
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            tests_run++;
            if (bus.count !== CNT_W'(4) || bus.fetch_pc !== PC_W'(5 + i) ||
                bus.deq_pc !== PC_W'(i + 1)) begin
                fail_cnt++;
                $display("FAIL full_drain[%0d]: got count=%0d pc=%h dpc=%h expected 4/%h/%h",
                         i, bus.count, bus.fetch_pc, bus.deq_pc, PC_W'(5 + i), PC_W'(i + 1));
            end
        end
    endtask

    task automatic test_empty_stream();
        do_reset();
        bus.deq_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.deq_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL empty_first: got dv=%0b expected 0", bus.deq_valid);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            tests_run++;
            if (bus.deq_valid !== 1'b1 || bus.deq_pc !== PC_W'(i) || bus.count !== CNT_W'(1)) begin
                fail_cnt++;
                $display("FAIL empty_stream[%0d]: got dv=%0b dpc=%h count=%0d expected 1/%h/1",
                         i, bus.deq_valid, bus.deq_pc, bus.count, PC_W'(i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.deq_ready = 1'b0;
        repeat (3) cycle();
        tests_run++;
        if (bus.count !== CNT_W'(3)) begin
            fail_cnt++;
            $display("FAIL redir_setup: got count=%0d expected 3", bus.count);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 5'h11;
        bus.deq_ready      = 1'b1;
        #1;
        tests_run++;
        if (bus.deq_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL redir_same_cycle: got dv=%0b expected 0", bus.deq_valid);
        end
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.count !== '0 || bus.fetch_pc !== 5'h11 || bus.deq_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL redir_flush: got count=%0d pc=%h dv=%0b expected 0/11/0",
                     bus.count, bus.fetch_pc, bus.deq_valid);
        end
        cycle();
        tests_run++;
        if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 5'h11 || bus.deq_inst !== 16'h1011) begin
            fail_cnt++;
            $display("FAIL redir_first: got dv=%0b pc=%h inst=%h expected 1/11/1011",
                     bus.deq_valid, bus.deq_pc, bus.deq_inst);
        end
        repeat (4) cycle();
    endtask

    task automatic test_back_to_back_redirect();
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = PC_W'($urandom_range(0, 31));
            cycle();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 5'h09;
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.count !== '0 || bus.fetch_pc !== 5'h09) begin
            fail_cnt++;
            $display("FAIL b2b_redirect: got count=%0d pc=%h expected 0/09", bus.count, bus.fetch_pc);
        end
        cycle();
        tests_run++;
        if (bus.deq_pc !== 5'h09) begin
            fail_cnt++;
            $display("FAIL b2b_first: got dpc=%h expected 09", bus.deq_pc);
        end
    endtask

    task automatic test_wrap();
        bus.deq_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 5'h1E;
        cycle();
        bus.redirect_valid = 1'b0;
        cycle();
        cycle();
        tests_run++;
        if (bus.fetch_pc !== 5'h00 || bus.deq_pc !== 5'h1F) begin
            fail_cnt++;
            $display("FAIL pc_wrap: got pc=%h dpc=%h expected 00/1F", bus.fetch_pc, bus.deq_pc);
        end
        cycle();
        tests_run++;
        if (bus.deq_pc !== 5'h00 || bus.deq_inst !== 16'h1000) begin
            fail_cnt++;
            $display("FAIL pc_wrap_next: got dpc=%h inst=%h expected 00/1000", bus.deq_pc, bus.deq_inst);
        end
        // Random backpressure drives the ring pointers around several times.
        for (int i = 0; i < 40; i++) begin
            bus.deq_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.deq_ready = 1'b1;
        repeat (6) cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.deq_ready = 1'b0;
        repeat (2) cycle();
        tests_run++;
        if (bus.count !== CNT_W'(2)) begin
            fail_cnt++;
            $display("FAIL arst_setup: got count=%0d expected 2", bus.count);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.count !== '0 || bus.deq_valid !== 1'b0 || bus.deq_pc !== '0 || bus.fetch_pc !== '0) begin
            fail_cnt++;
            $display("FAIL arst_immediate: got count=%0d dv=%0b dpc=%h pc=%h expected 0/0/0/0",
                     bus.count, bus.deq_valid, bus.deq_pc, bus.fetch_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        m_pc    = '0;
        m_count = 0;
        exp_q.delete();
        bus.deq_ready = 1'b1;
        repeat (3) cycle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_drain();
        test_empty_stream();
        test_redirect();
        test_back_to_back_redirect();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
